sgdma_desc_chain_fetcher: RTL and testbench

Avalon-MM master that walks a linked chain of 4-word DMA descriptors held in the on-chip descriptor memory. It sits between that memory's slave port and the DMA datapath. It fetches each descriptor, hands it to the datapath over a valid/ready stream, and waits for the completion. It then writes status back into the descriptor and follows the next pointer until it reaches a descriptor not owned by hardware.

---
 rtl/sgdma_desc_pkg.sv | 29 ++
 rtl/sgdma_desc_rd_collector.sv | 85 ++++++++
 rtl/sgdma_desc_chain_fetcher.sv | 222 ++++++++++++++++++++++
 tb/tb_sgdma_desc_chain_fetcher.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgdma_desc_pkg.sv
// Shared types and constants for the descriptor chain fetcher.
package sgdma_desc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_COLLECT,
    ST_PRESENT,
    ST_WAIT_CMPL,
    ST_WB,
    ST_NEXT
  } state_e;

  localparam int unsigned DESC_WORDS  = 4;
  localparam int unsigned DESC_W_SRC  = 0;
  localparam int unsigned DESC_W_DST  = 1;
  localparam int unsigned DESC_W_NEXT = 2;
  localparam int unsigned DESC_W_CTRL = 3;

  localparam int unsigned OWN_BIT     = 31;
  localparam int unsigned LEN_LSB     = 0;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned CTRL_LSB    = 16;
  localparam int unsigned CTRL_W      = 15;
  localparam int unsigned STATUS_LSB  = 24;

  localparam logic [3:0] WB_BYTEENABLE = 4'b1000;

endpackage

// File: rtl/sgdma_desc_rd_collector.sv
// Outstanding-read tracking and capture of read beats into descriptor slots.
module sgdma_desc_rd_collector
  import sgdma_desc_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              rd_accept,
  input  logic              rdv,
  input  logic [31:0]       rdata,
  output logic [CNT_W-1:0]  outst_nxt,
  output logic              collect_done,
  output logic              own,
  output logic [31:0]       src,
  output logic [31:0]       dst,
  output logic [ADDR_W-1:0] next_ptr,
  output logic [LEN_W-1:0]  len,
  output logic [CTRL_W-1:0] ctrl
);

  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [2:0]        beat_q, beat_d;
  logic [31:0]       src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0] next_q, next_d;
  logic [30:0]       lenctrl_q, lenctrl_d;

  // Count reads in flight and steer beats into slots in request order.
  always_comb begin
    outst_d   = outst_q;
    beat_d    = beat_q;
    src_d     = src_q;
    dst_d     = dst_q;
    next_d    = next_q;
    lenctrl_d = lenctrl_q;
    if (rd_accept && !rdv)
      outst_d = outst_q + CNT_W'(1);
    else if (!rd_accept && rdv && outst_q != '0)
      outst_d = outst_q - CNT_W'(1);
    if (clear) begin
      beat_d = '0;
    end else if (rdv && beat_q < 3'(DESC_WORDS)) begin
      beat_d = beat_q + 3'd1;
      case (beat_q)
        3'(DESC_W_SRC):  src_d     = rdata;
        3'(DESC_W_DST):  dst_d     = rdata;
        3'(DESC_W_NEXT): next_d    = rdata[ADDR_W-1:0];
        3'(DESC_W_CTRL): lenctrl_d = rdata[30:0];
        default: ;
      endcase
    end
  end

  // Collector state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outst_q   <= '0;
      beat_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      next_q    <= '0;
      lenctrl_q <= '0;
    end else begin
      outst_q   <= outst_d;
      beat_q    <= beat_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      next_q    <= next_d;
      lenctrl_q <= lenctrl_d;
    end
  end

  // The last beat is the ctrl word, so OWN is taken straight off the bus.
  assign collect_done = rdv && !clear && (beat_q == 3'(DESC_WORDS - 1));
  assign own          = rdata[OWN_BIT];
  assign outst_nxt    = outst_d;
  assign src          = src_q;
  assign dst          = dst_q;
  assign next_ptr     = next_q;
  assign len          = lenctrl_q[LEN_LSB +: LEN_W];
  assign ctrl         = lenctrl_q[CTRL_LSB +: CTRL_W];

endmodule

// File: rtl/sgdma_desc_chain_fetcher.sv
// Avalon-MM master walking a linked chain of 4-word DMA descriptors.
// Optional status writeback: define SGDMA_DESC_WRITEBACK_EN.
module sgdma_desc_chain_fetcher
  import sgdma_desc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_ptr,
  output logic              busy,
  output logic              chain_done,
  output logic              err,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [15:0]       desc_len,
  output logic [14:0]       desc_ctrl,
  input  logic              cmpl_valid,
  input  logic [6:0]        cmpl_status
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [2:0]        iss_q, iss_d;
  logic              busy_q, busy_d, chain_done_q, chain_done_d, err_q, err_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic              m_read_q, m_read_d;
  logic [31:0]       m_writedata_q, m_writedata_d;
  logic              desc_valid_q, desc_valid_d;
`ifdef SGDMA_DESC_WRITEBACK_EN
  logic              m_write_q, m_write_d;
`endif

  logic              clear, rd_accept, collect_done, own;
  logic [CNT_W-1:0]  outst_nxt;
  logic [ADDR_W-1:0] next_ptr;

  assign rd_accept = m_read_q & ~m_waitrequest;

  sgdma_desc_rd_collector #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_collector (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .rd_accept    (rd_accept),
    .rdv          (m_readdatavalid),
    .rdata        (m_readdata),
    .outst_nxt    (outst_nxt),
    .collect_done (collect_done),
    .own          (own),
    .src          (desc_src),
    .dst          (desc_dst),
    .next_ptr     (next_ptr),
    .len          (desc_len),
    .ctrl         (desc_ctrl)
  );

  // Chain-walk FSM next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    iss_d         = iss_q;
    busy_d        = busy_q;
    chain_done_d  = 1'b0;
    err_d         = err_q;
    m_address_d   = m_address_q;
    m_read_d      = m_read_q;
    m_writedata_d = m_writedata_q;
    desc_valid_d  = desc_valid_q;
    clear         = 1'b0;
`ifdef SGDMA_DESC_WRITEBACK_EN
    m_write_d     = m_write_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ptr[3:0] != 4'h0) begin
            err_d = 1'b1;
          end else begin
            err_d       = 1'b0;
            busy_d      = 1'b1;
            cur_d       = start_ptr;
            m_address_d = start_ptr;
            iss_d       = '0;
            m_read_d    = 1'b1;
            clear       = 1'b1;
            state_d     = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: begin
        if (rd_accept) begin
          iss_d       = iss_q + 3'd1;
          m_address_d = cur_q + ADDR_W'({iss_d, 2'b00});
        end
        if (iss_d == 3'(DESC_WORDS)) begin
          m_read_d = 1'b0;
          state_d  = ST_RD_COLLECT;
        end else begin
          // Re-evaluated every cycle so issue resumes once a beat frees a slot.
          m_read_d = (outst_nxt < CNT_W'(MAX_OUTST));
        end
      end
      ST_RD_COLLECT: begin
        if (collect_done) begin
          if (!own) begin
            chain_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            desc_valid_d = 1'b1;
            state_d      = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        if (desc_ready) begin
          desc_valid_d = 1'b0;
          state_d      = ST_WAIT_CMPL;
        end
      end
      ST_WAIT_CMPL: begin
        if (cmpl_valid) begin
          m_writedata_d = '0;
          m_writedata_d[STATUS_LSB +: 8] = {1'b0, cmpl_status};
`ifdef SGDMA_DESC_WRITEBACK_EN
          m_write_d   = 1'b1;
          m_address_d = cur_q + ADDR_W'(4 * DESC_W_CTRL);
          state_d     = ST_WB;
`else
          state_d     = ST_NEXT;
`endif
        end
      end
`ifdef SGDMA_DESC_WRITEBACK_EN
      ST_WB: begin
        if (!m_waitrequest) begin
          m_write_d = 1'b0;
          state_d   = ST_NEXT;
        end
      end
`endif
      ST_NEXT: begin
        if (next_ptr[3:0] != 4'h0) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cur_d       = next_ptr;
          m_address_d = next_ptr;
          iss_d       = '0;
          m_read_d    = 1'b1;
          clear       = 1'b1;
          state_d     = ST_RD_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      iss_q         <= '0;
      busy_q        <= 1'b0;
      chain_done_q  <= 1'b0;
      err_q         <= 1'b0;
      m_address_q   <= '0;
      m_read_q      <= 1'b0;
      m_writedata_q <= '0;
      desc_valid_q  <= 1'b0;
`ifdef SGDMA_DESC_WRITEBACK_EN
      m_write_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      iss_q         <= iss_d;
      busy_q        <= busy_d;
      chain_done_q  <= chain_done_d;
      err_q         <= err_d;
      m_address_q   <= m_address_d;
      m_read_q      <= m_read_d;
      m_writedata_q <= m_writedata_d;
      desc_valid_q  <= desc_valid_d;
`ifdef SGDMA_DESC_WRITEBACK_EN
      m_write_q     <= m_write_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign chain_done  = chain_done_q;
  assign err         = err_q;
  assign m_address   = m_address_q;
  assign m_read      = m_read_q;
  assign m_writedata = m_writedata_q;
  assign desc_valid  = desc_valid_q;
`ifdef SGDMA_DESC_WRITEBACK_EN
  assign m_write      = m_write_q;
  assign m_byteenable = m_write_q ? WB_BYTEENABLE : (m_read_q ? 4'hF : 4'h0);
`else
  assign m_write      = 1'b0;
  assign m_byteenable = '0;
`endif

endmodule

// File: tb/tb_sgdma_desc_chain_fetcher.sv
// Self-checking bench for sgdma_desc_chain_fetcher (either writeback build).
module tb_sgdma_desc_chain_fetcher;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_ptr;
  logic          busy, chain_done, err;
  logic [AW-1:0] m_address;
  logic          m_read, m_write;
  logic [3:0]    m_byteenable;
  logic [31:0]   m_writedata;
  logic          m_waitrequest;
  logic [31:0]   m_readdata;
  logic          m_readdatavalid;
  logic          desc_valid, desc_ready;
  logic [31:0]   desc_src, desc_dst;
  logic [15:0]   desc_len;
  logic [14:0]   desc_ctrl;
  logic          cmpl_valid;
  logic [6:0]    cmpl_status;

  sgdma_desc_chain_fetcher #(.ADDR_W(AW), .MAX_OUTST(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ptr(start_ptr),
    .busy(busy), .chain_done(chain_done), .err(err),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .desc_ctrl(desc_ctrl), .cmpl_valid(cmpl_valid), .cmpl_status(cmpl_status)
  );

  always #5 clk = ~clk;

`ifdef SGDMA_DESC_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [15:0]   len;
    logic [14:0]   ctrl;
  } desc_t;

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   due;
  } pend_t;

  typedef struct {
    logic [AW-1:0] sp;
    int unsigned   setup;
    bit            rnd;
    int            nd;
    int            dn;
    int            er;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [2048];
  desc_t         exp_desc[$];
  logic [AW-1:0] exp_rd[$];
  int            exp_done, exp_err;

  logic [AW-1:0] rd_log[$];
  pend_t         pend[$];
  int unsigned   cyc = 0;
  int            outst = 0, max_outst = 0, viol = 0;
  int            got_cnt = 0, wr_cnt = 0, done_cnt = 0;
  bit            rnd_mode = 0, ready_en = 1;
  int unsigned   lat_fixed = 1;
  bit            cmpl_pending = 0;
  int unsigned   cmpl_delay = 0;
  logic [6:0]    cmpl_next = '0, last_status = '0;
  logic [AW-1:0] last_desc_addr = '0;
  bit            stall_prev = 0;
  logic [50:0]   prev_bus = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic put_desc(input logic [AW-1:0] a, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] nx, input bit own, input logic [14:0] c,
                          input logic [15:0] l);
    logic [10:0] wi;
    wi = a[AW-1:2];
    mem[wi]         = s;
    mem[wi + 11'd1] = d;
    mem[wi + 11'd2] = nx;
    mem[wi + 11'd3] = {own, c, l};
  endtask

  task automatic setup_mem(input int unsigned id);
    foreach (mem[i]) mem[i] = '0;
    case (id)
      0: begin
        put_desc(13'h000, 32'h1000_0000, 32'h2000_0000, 32'h10, 1'b1, 15'h1234, 16'h0100);
        put_desc(13'h010, 32'h1000_1000, 32'h2000_2000, 32'h20, 1'b1, 15'h0ABC, 16'h0040);
        put_desc(13'h020, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h30, 1'b0, 15'h7FFF, 16'hFFFF);
      end
      2: begin
        put_desc(13'h040, 32'h3000_0000, 32'h4000_0000, 32'h14, 1'b1, 15'h0055, 16'h0020);
        put_desc(13'h010, 32'h5555_5555, 32'h6666_6666, 32'h00, 1'b1, 15'h0001, 16'h0001);
      end
      3: begin
        put_desc(13'h100, 32'h7000_0000, 32'h7100_0000, 32'h100, 1'b1, 15'h2222, 16'h0800);
        put_desc(13'h1FF0, 32'h8000_0000, 32'h8100_0000, 32'h30, 1'b1, 15'h3333, 16'h0010);
        put_desc(13'h030, 32'h0, 32'h0, 32'h0, 1'b0, 15'h0, 16'h0);
      end
      default: ;
    endcase
  endtask

  // Reference walk of the chain over a snapshot of memory.
  task automatic model_walk(input logic [AW-1:0] sp);
    logic [31:0]   mm [2048];
    logic [AW-1:0] p;
    logic [10:0]   wi;
    logic [31:0]   w3, nx;
    desc_t         d;
    mm = mem;
    exp_desc.delete();
    exp_rd.delete();
    exp_done = 0;
    exp_err  = 0;
    if (sp[3:0] != 4'h0) begin
      exp_err = 1;
      return;
    end
    p = sp;
    for (int n = 0; n < 64; n++) begin
      for (int k = 0; k < 4; k++) exp_rd.push_back(p + AW'(4 * k));
      wi = p[AW-1:2];
      w3 = mm[wi + 11'd3];
      if (!w3[31]) begin
        exp_done = 1;
        return;
      end
      d.addr = p; d.src = mm[wi]; d.dst = mm[wi + 11'd1];
      d.len = w3[15:0]; d.ctrl = w3[30:16];
      exp_desc.push_back(d);
      if (WB) mm[wi + 11'd3][31] = 1'b0;
      nx = mm[wi + 11'd2];
      if (nx[3:0] != 4'h0) begin
        exp_err = 1;
        return;
      end
      p = nx[AW-1:0];
    end
  endtask

  // Slave and completion drivers, updated away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      pend.delete();
      m_readdatavalid = 1'b0;
      m_waitrequest   = 1'b0;
      cmpl_valid      = 1'b0;
      cmpl_pending    = 0;
    end else begin
      m_waitrequest = rnd_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        m_readdatavalid = 1'b1;
        m_readdata      = mem[pend[0].addr[AW-1:2]];
        void'(pend.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = $urandom;
      end
      desc_ready = ready_en && (rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
      cmpl_valid = 1'b0;
      if (cmpl_pending) begin
        if (cmpl_delay == 0) begin
          cmpl_valid   = 1'b1;
          cmpl_status  = cmpl_next;
          last_status  = cmpl_next;
          cmpl_pending = 0;
        end else begin
          cmpl_delay--;
        end
      end
    end
  end

  // Bus and stream monitor sampling pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      if (m_readdatavalid) outst--;
      if (m_read && !m_waitrequest) begin
        pend_t pe;
        rd_log.push_back(m_address);
        pe.addr = m_address;
        pe.due  = cyc + (rnd_mode ? $urandom_range(1, 3) : lat_fixed) - 1;
        pend.push_back(pe);
        outst++;
      end
      if (outst > max_outst) max_outst = outst;
      if (m_read && m_write) viol++;
      if (stall_prev && {m_read, m_write, m_address, m_byteenable, m_writedata} != prev_bus) viol++;
      stall_prev = (m_read || m_write) && m_waitrequest;
      prev_bus   = {m_read, m_write, m_address, m_byteenable, m_writedata};
      if (m_write && !m_waitrequest) begin
        wr_cnt++;
        check("wb_addr", 64'(m_address), 64'(last_desc_addr + AW'(12)));
        check("wb_be", 64'(m_byteenable), 64'h8);
        check("wb_data", 64'(m_writedata[31:24]), 64'({1'b0, last_status}));
        mem[m_address[AW-1:2]][31:24] = m_writedata[31:24];
      end
      if (desc_valid && desc_ready) begin
        if (got_cnt < exp_desc.size()) begin
          check("desc_fields", {desc_src, desc_len, desc_ctrl[14:0]} ^ 64'(desc_dst),
                {exp_desc[got_cnt].src, exp_desc[got_cnt].len, exp_desc[got_cnt].ctrl}
                  ^ 64'(exp_desc[got_cnt].dst));
          last_desc_addr = exp_desc[got_cnt].addr;
        end else begin
          check("desc_extra", 64'(got_cnt), 64'(exp_desc.size()));
        end
        got_cnt++;
        cmpl_pending = 1;
        cmpl_delay   = $urandom_range(0, 3);
        cmpl_next    = 7'($urandom_range(0, 127));
      end
      if (chain_done) done_cnt++;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic clear_run();
    rd_log.delete();
    got_cnt = 0; wr_cnt = 0; done_cnt = 0; viol = 0; max_outst = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] sp);
    @(negedge clk);
    start_ptr = sp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({nm, "_timeout"}, 64'(busy), 64'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic finish_checks(input string nm, input int nd, input int dn, input int er);
    int mism;
    mism = (rd_log.size() != exp_rd.size()) ? 1 : 0;
    if (mism == 0)
      foreach (exp_rd[i]) if (rd_log[i] !== exp_rd[i]) mism++;
    check({nm, "_ndesc"}, 64'(got_cnt), 64'(nd));
    check({nm, "_done_pulses"}, 64'(done_cnt), 64'(dn));
    check({nm, "_err"}, 64'(err), 64'(er));
    check({nm, "_busy"}, 64'(busy), 64'h0);
    check({nm, "_rd_addrs"}, 64'(mism), 64'h0);
    check({nm, "_writes"}, 64'(wr_cnt), WB ? 64'(nd) : 64'h0);
    check({nm, "_outst_le4"}, 64'(max_outst > 4), 64'h0);
    check({nm, "_bus_rules"}, 64'(viol), 64'h0);
  endtask

  task automatic run_one(input string nm, input logic [AW-1:0] sp, input bit rnd,
                         input bit use_tbl, input int nd, input int dn, input int er);
    rnd_mode = rnd;
    model_walk(sp);
    clear_run();
    pulse_start(sp);
    check({nm, "_first_read"}, 64'(m_read), 64'(sp[3:0] == 4'h0));
    wait_idle(nm);
    if (use_tbl) finish_checks(nm, nd, dn, er);
    else         finish_checks(nm, exp_desc.size(), exp_done, exp_err);
  endtask

  vec_t tbl[6];

  initial begin
    reset_n = 1'b0; start = 1'b0; start_ptr = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    desc_ready = 1'b0; cmpl_valid = 1'b0; cmpl_status = '0;

    tbl[0] = '{13'h000, 0, 1'b0, 2, 1, 0};
    tbl[1] = '{13'h000, 0, 1'b1, 2, 1, 0};
    tbl[2] = '{13'h040, 2, 1'b0, 1, 0, 1};
    tbl[3] = '{13'h004, 0, 1'b0, 0, 0, 1};
    tbl[4] = WB ? '{13'h100, 3, 1'b1, 1, 1, 0} : '{13'h1FF0, 3, 1'b1, 1, 1, 0};
    tbl[5] = '{13'h040, 2, 1'b1, 1, 0, 1};

    repeat (3) @(negedge clk);
    check("reset_bus", 64'({m_address, m_read, m_write, m_byteenable, m_writedata}), 64'h0);
    check("reset_status", 64'(|{busy, chain_done, err, desc_valid, desc_src, desc_dst,
                                 desc_len, desc_ctrl}), 64'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      setup_mem(tbl[i].setup);
      run_one($sformatf("vec%0d", i), tbl[i].sp, tbl[i].rnd, 1'b1,
              tbl[i].nd, tbl[i].dn, tbl[i].er);
    end

    for (int r = 0; r < 8; r++) begin
      int unsigned n, b;
      logic [AW-1:0] a, an;
      setup_mem(99);
      n = $urandom_range(1, 4);
      b = $urandom_range(0, 511);
      for (int unsigned i = 0; i <= n; i++) begin
        a  = AW'(((b + i * 37) % 512) * 16);
        an = AW'(((b + (i + 1) * 37) % 512) * 16);
        if (i == n - 1 && $urandom_range(0, 3) == 0) an = an + AW'(4);
        put_desc(a, $urandom, $urandom, 32'(an), i < n, 15'($urandom), 16'($urandom));
      end
      run_one($sformatf("rand%0d", r), AW'((b % 512) * 16), 1'b1, 1'b0, 0, 0, 0);
    end

    // desc_ready held low: fields and bus must stay quiet, stray start ignored.
    begin
      int n, bad;
      logic [94:0] snap;
      setup_mem(0);
      rnd_mode = 0;
      ready_en = 0;
      model_walk(13'h000);
      clear_run();
      pulse_start(13'h000);
      n = 0;
      while (!desc_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("hold_valid_seen", 64'(desc_valid), 64'h1);
      snap = {desc_src, desc_dst, desc_len, desc_ctrl};
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        start_ptr = 13'h040;
        start = (c == 5);
        @(negedge clk);
        if ({desc_src, desc_dst, desc_len, desc_ctrl} != snap || m_read || m_write || !desc_valid)
          bad++;
      end
      start = 1'b0;
      check("hold_stable", 64'(bad), 64'h0);
      ready_en = 1;
      wait_idle("hold");
      finish_checks("hold", 2, 1, 0);
    end

    // Reset during RD_COLLECT, then a clean restart.
    begin
      int n;
      setup_mem(0);
      rnd_mode = 0;
      lat_fixed = 3;
      clear_run();
      pulse_start(13'h000);
      n = 0;
      while (rd_log.size() < 4 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rst_reached_collect", 64'(rd_log.size()), 64'h4);
      reset_n = 1'b0;
      #1;
      check("rst_async_bus", 64'({m_address, m_read, m_write, m_byteenable, m_writedata}), 64'h0);
      check("rst_async_status", 64'(|{busy, chain_done, err, desc_valid, desc_src, desc_dst,
                                     desc_len, desc_ctrl}), 64'h0);
      pend.delete();
      outst = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      lat_fixed = 1;
      run_one("after_rst", 13'h000, 1'b0, 1'b1, 2, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
